flit_demux: RTL and testbench
=============================

Name: flit_demux

Overview:
- Packet-level 1:2 demultiplexer for the NoC flit interface; the receive-side counterpart of the 2:1 output mux.
- Accepts one flit stream (data, valid, vch) and reads the destination from each HEAD flit.
- Steers the whole packet, HEAD through TAIL, to output port 0 or 1, with a small FIFO per output.
- Provides backpressure upstream and a ready/valid handshake downstream; sits between a link receiver and two router input ports.

Parameters:
DATAW, 66, flit width in bits; bits [DATAW-1:DATAW-2] are the flit type, bits [31:0] the HEAD destination field
VCHW, 1, virtual-channel id width in bits
DEPTH, 4, entries per output FIFO (power of two, >=2)
ROUTE_BIT, 0, destination bit that selects the output port (0 -> port 0, 1 -> port 1)

Ports:
clk  in  1  system clock, rising edge
rst_  in  1  asynchronous active-low reset
idata  in  DATAW  input flit
ivalid  in  1  input flit valid
ivch  in  VCHW  input virtual channel
iready  out  1  demux can accept the flit presented this cycle
odata_0  out  DATAW  port 0 flit (FIFO head)
ovalid_0  out  1  port 0 flit valid
ovch_0  out  VCHW  port 0 virtual channel
ordy_0  in  1  port 0 consumer ready
odata_1  out  DATAW  port 1 flit
ovalid_1  out  1  port 1 flit valid
ovch_1  out  VCHW  port 1 virtual channel
ordy_1  in  1  port 1 consumer ready
err_drop  out  1  one-cycle pulse when a flit is discarded
drop_cnt  out  8  saturating count of discarded flits

Behaviour:
- Reset and interface:
  - One clock domain; clk is the only clock.
  - rst_ is asynchronous and active-low: asserting rst_ at any time, including mid-packet, empties both FIFOs and forces state IDLE.
  - Reset values: ovalid_x=0, odata_x=0, ovch_x=0, err_drop=0, drop_cnt=0, iready=1.
- Flit types (2-bit code): NONE=00, HEAD=01, DATA=10, TAIL=11.
- A flit is accepted when ivalid=1, iready=1 and type!=NONE. NONE flits with ivalid=1 are ignored silently and are not counted.
- Target port p:
  - In IDLE, p = idata[ROUTE_BIT].
  - In BUSY_p, p is the latched route.
- iready = !full(FIFO[p]), combinational. No pass-through: a full FIFO never accepts, even if it pops in the same cycle.
- State machine:
  - IDLE, accepted HEAD: push to FIFO[p], latch p, go to BUSY_p.
  - IDLE, accepted DATA/TAIL: discard, pulse err_drop, stay in IDLE.
  - BUSY_p, accepted DATA: push to FIFO[p].
  - BUSY_p, accepted TAIL: push to FIFO[p], go to IDLE. The next HEAD can be accepted the following cycle.
  - BUSY_p, accepted HEAD: discard (protocol error), pulse err_drop, stay in BUSY_p.
- FIFO entry = {vch, flit}; vch is stored per flit and is not latched at HEAD.
- Output side:
  - ovalid_x = !empty(FIFO[x]); odata_x and ovch_x are the FIFO head entry, registered storage.
  - Pop when ovalid_x & ordy_x.
  - odata_x/ovch_x hold their last value when empty.
- Latency: a flit accepted at edge N is visible on its output immediately after edge N.
- Throughput: 1 flit/cycle sustained while the consumer holds ordy=1.
- Simultaneous push and pop on the same FIFO: occupancy unchanged; correct order is preserved, including at pointer wrap-around.
- The two ports drain independently. A stalled port blocks iready only while that port is the target.
- drop_cnt increments on each err_drop and saturates at 255.

Decomposition:
- Shared package flit_pkg: flit type codes (NONE/HEAD/DATA/TAIL), type field position, DATAW/VCHW defaults, ROUTE_BIT default.
- Sub-module flit_fifo: synchronous FIFO with parameters WIDTH and DEPTH; ports push, pop, din, dout, full, empty; asynchronous active-low reset. Instantiated twice with WIDTH=DATAW+VCHW.
- flit_demux holds the route FSM, accept logic and error counter.

Test Plan:
- Packet to port 1: HEAD dest=0x09, 20 DATA, TAIL, ordy_1=1 -> 22 flits appear on port 1 in order, one cycle after acceptance; ovalid_0 stays 0; iready=1 throughout.
- Packet to port 0: HEAD dest=0x04, 3 DATA, TAIL, vch=1 -> 5 flits on port 0 with ovch_0=1; the FSM returns to IDLE after TAIL.
- Backpressure: ordy_0=0, send HEAD dest=0x04 plus 5 DATA -> iready drops to 0 after 4 accepted flits. Then set ordy_0=1 -> all 6 flits drain in order, and iready recovers the cycle after the first pop.
- Protocol errors: DATA in IDLE -> err_drop pulses, drop_cnt=1, no output. HEAD while BUSY_0 -> dropped, drop_cnt=2, packet continues to port 0. Force 300 errors -> drop_cnt=255.
- Back-to-back packets: TAIL to port 0 then HEAD dest=0x09 on the next cycle -> the HEAD goes to port 1 with no bubble. With port 0 stalled and full, port 1 traffic still flows.
- Reset mid-packet: assert rst_ asynchronously after HEAD plus 2 DATA -> ovalid_0/1=0 immediately, state IDLE. After release, a DATA flit is dropped (err_drop=1) and a new HEAD routes normally.

Source files
------------

// File: rtl/flit_pkg.sv
// rtl/flit_pkg.sv - shared flit type codes, field positions and defaults for the flit demux
package flit_pkg;

   typedef enum logic [1:0] {
      FLIT_NONE = 2'b00,
      FLIT_HEAD = 2'b01,
      FLIT_DATA = 2'b10,
      FLIT_TAIL = 2'b11
   } flit_type_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_BUSY0 = 2'b01,
      ST_BUSY1 = 2'b10
   } route_state_e;

   localparam int TYPE_W        = 2;
   localparam int DEST_W        = 32;
   localparam int DATAW_DEF     = 66;
   localparam int VCHW_DEF      = 1;
   localparam int DEPTH_DEF     = 4;
   localparam int ROUTE_BIT_DEF = 0;

endpackage

// File: rtl/flit_fifo.sv
// rtl/flit_fifo.sv - synchronous FIFO with registered head output that holds its last value when empty
module flit_fifo #(
   parameter int WIDTH = 67,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic [WIDTH-1:0] r_dout;

   logic             w_do_push;
   logic             w_do_pop;
   logic [AW-1:0]    w_rd_nxt;
   logic [AW:0]      w_cnt_nxt;
   logic [WIDTH-1:0] w_head_nxt;

   assign full  = (r_count == FULL_CNT);
   assign empty = (r_count == '0);
   assign dout  = r_dout;

   // No pass-through: a full FIFO refuses a push even when it pops this cycle.
   assign w_do_push = push & ~full;
   assign w_do_pop  = pop & ~empty;

   always_comb begin
      w_rd_nxt  = w_do_pop ? r_rd_ptr + PTR_ONE : r_rd_ptr;
      w_cnt_nxt = r_count;
      if (w_do_push && !w_do_pop) begin
         w_cnt_nxt = r_count + CNT_ONE;
      end else if (!w_do_push && w_do_pop) begin
         w_cnt_nxt = r_count - CNT_ONE;
      end
      // The head after this edge is the incoming word only when it becomes the sole entry.
      w_head_nxt = (w_do_push && (w_rd_nxt == r_wr_ptr)) ? din : r_mem[w_rd_nxt];
   end

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_dout   <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         r_rd_ptr <= w_rd_nxt;
         r_count  <= w_cnt_nxt;
         if (w_cnt_nxt != '0) begin
            r_dout <= w_head_nxt;
         end
      end
   end

endmodule

// File: rtl/flit_demux.sv
// rtl/flit_demux.sv - packet-level 1:2 flit demultiplexer with per-port FIFOs and drop accounting
module flit_demux
   import flit_pkg::*;
#(
   parameter int DATAW     = DATAW_DEF,
   parameter int VCHW      = VCHW_DEF,
   parameter int DEPTH     = DEPTH_DEF,
   parameter int ROUTE_BIT = ROUTE_BIT_DEF
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic [DATAW-1:0] idata,
   input  logic             ivalid,
   input  logic [VCHW-1:0]  ivch,
   output logic             iready,
   output logic [DATAW-1:0] odata_0,
   output logic             ovalid_0,
   output logic [VCHW-1:0]  ovch_0,
   input  logic             ordy_0,
   output logic [DATAW-1:0] odata_1,
   output logic             ovalid_1,
   output logic [VCHW-1:0]  ovch_1,
   input  logic             ordy_1,
   output logic             err_drop,
   output logic [7:0]       drop_cnt
);

   localparam int EW = DATAW + VCHW;

   route_state_e r_state;
   route_state_e w_state_nxt;
   logic         r_err_drop;
   logic [7:0]   r_drop_cnt;

   flit_type_e   w_type;
   logic         w_tgt;
   logic         w_accept;
   logic         w_push;
   logic         w_drop;
   logic         w_full0, w_full1, w_empty0, w_empty1;
   logic [EW-1:0] w_dout0, w_dout1;

   assign w_type = flit_type_e'(idata[DATAW-1 -: TYPE_W]);

   // In IDLE the HEAD's destination bit picks the port; inside a packet the latched route does.
   assign w_tgt    = (r_state == ST_IDLE) ? idata[ROUTE_BIT] : (r_state == ST_BUSY1);
   assign iready   = w_tgt ? ~w_full1 : ~w_full0;
   assign w_accept = ivalid & iready & (w_type != FLIT_NONE);

   always_comb begin
      w_state_nxt = r_state;
      w_push      = 1'b0;
      w_drop      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (w_type == FLIT_HEAD) begin
                  w_push      = 1'b1;
                  w_state_nxt = w_tgt ? ST_BUSY1 : ST_BUSY0;
               end else begin
                  w_drop = 1'b1;
               end
            end
         end
         ST_BUSY0, ST_BUSY1: begin
            if (w_accept) begin
               if (w_type == FLIT_HEAD) begin
                  w_drop = 1'b1;
               end else begin
                  w_push = 1'b1;
                  if (w_type == FLIT_TAIL) begin
                     w_state_nxt = ST_IDLE;
                  end
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         r_state    <= ST_IDLE;
         r_err_drop <= 1'b0;
         r_drop_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_err_drop <= w_drop;
         if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
         end
      end
   end

   assign err_drop = r_err_drop;
   assign drop_cnt = r_drop_cnt;

   flit_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo0 (
      .clk   (clk),
      .rst_  (rst_),
      .push  (w_push & ~w_tgt),
      .pop   (ordy_0 & ~w_empty0),
      .din   ({ivch, idata}),
      .dout  (w_dout0),
      .full  (w_full0),
      .empty (w_empty0)
   );

   flit_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo1 (
      .clk   (clk),
      .rst_  (rst_),
      .push  (w_push & w_tgt),
      .pop   (ordy_1 & ~w_empty1),
      .din   ({ivch, idata}),
      .dout  (w_dout1),
      .full  (w_full1),
      .empty (w_empty1)
   );

   assign ovalid_0 = ~w_empty0;
   assign odata_0  = w_dout0[DATAW-1:0];
   assign ovch_0   = w_dout0[EW-1 -: VCHW];
   assign ovalid_1 = ~w_empty1;
   assign odata_1  = w_dout1[DATAW-1:0];
   assign ovch_1   = w_dout1[EW-1 -: VCHW];

endmodule

// File: tb/tb_flit_demux.sv
// tb/tb_flit_demux.sv - self-checking bench for flit_demux against a queue-based packet model
module tb_flit_demux;

   localparam int DATAW = 66;
   localparam int DEPTH = 4;
   localparam logic [1:0] T_NONE = 2'b00, T_HEAD = 2'b01, T_DATA = 2'b10, T_TAIL = 2'b11;

   logic             clk = 1'b0;
   logic             rst_;
   logic [DATAW-1:0] idata;
   logic             ivalid;
   logic [0:0]       ivch;
   logic             iready;
   logic [DATAW-1:0] odata_0, odata_1;
   logic             ovalid_0, ovalid_1;
   logic [0:0]       ovch_0, ovch_1;
   logic             ordy_0, ordy_1;
   logic             err_drop;
   logic [7:0]       drop_cnt;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: packet state, per-port queues of {vch, flit}, last shown head, drop count.
   logic [DATAW:0] q0[$];
   logic [DATAW:0] q1[$];
   logic [DATAW:0] last0, last1;
   bit             m_busy;
   bit             m_route;
   int             m_cnt;
   bit             m_drop;

   flit_demux dut (
      .clk(clk), .rst_(rst_),
      .idata(idata), .ivalid(ivalid), .ivch(ivch), .iready(iready),
      .odata_0(odata_0), .ovalid_0(ovalid_0), .ovch_0(ovch_0), .ordy_0(ordy_0),
      .odata_1(odata_1), .ovalid_1(ovalid_1), .ovch_1(ovch_1), .ordy_1(ordy_1),
      .err_drop(err_drop), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DATAW:0] obs, input logic [DATAW:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DATAW-1:0] mk(input logic [1:0] t, input logic [31:0] lo);
      logic [31:0] hi;
      hi = $urandom;
      return {t, hi, lo};
   endfunction

   task automatic model_clear();
      q0.delete();
      q1.delete();
      last0  = '0;
      last1  = '0;
      m_busy = 0;
      m_route = 0;
      m_cnt  = 0;
      m_drop = 0;
   endtask

   task automatic check_outputs();
      if (q0.size() != 0) last0 = q0[0];
      if (q1.size() != 0) last1 = q1[0];
      chk("ovalid_0", ovalid_0, q0.size() != 0);
      chk("ovalid_1", ovalid_1, q1.size() != 0);
      chk("odata_0", odata_0, last0[DATAW-1:0]);
      chk("odata_1", odata_1, last1[DATAW-1:0]);
      chk("ovch_0", ovch_0, last0[DATAW]);
      chk("ovch_1", ovch_1, last1[DATAW]);
      chk("err_drop", err_drop, m_drop);
      chk("drop_cnt", drop_cnt, m_cnt);
   endtask

   // One clock cycle: present inputs, check iready, clock, update model, check outputs.
   task automatic step(input logic [DATAW-1:0] d, input logic v, input logic vc, output bit acc);
      bit tgt, exp_rdy, pop0, pop1;
      logic [DATAW:0] ent;
      idata = d; ivalid = v; ivch = vc;
      #2;
      tgt     = m_busy ? m_route : d[0];
      exp_rdy = (tgt ? q1.size() : q0.size()) < DEPTH;
      chk("iready", iready, exp_rdy);
      acc  = v && exp_rdy && (d[DATAW-1 -: 2] != T_NONE);
      pop0 = (q0.size() != 0) && ordy_0;
      pop1 = (q1.size() != 0) && ordy_1;
      @(posedge clk);
      #1;
      if (pop0) void'(q0.pop_front());
      if (pop1) void'(q1.pop_front());
      ent    = {vc, d};
      m_drop = 0;
      if (acc) begin
         if (!m_busy) begin
            if (d[DATAW-1 -: 2] == T_HEAD) begin
               m_busy = 1; m_route = tgt;
               if (tgt) q1.push_back(ent); else q0.push_back(ent);
            end else m_drop = 1;
         end else if (d[DATAW-1 -: 2] == T_HEAD) begin
            m_drop = 1;
         end else begin
            if (m_route) q1.push_back(ent); else q0.push_back(ent);
            if (d[DATAW-1 -: 2] == T_TAIL) m_busy = 0;
         end
      end
      if (m_drop && m_cnt < 255) m_cnt++;
      check_outputs();
   endtask

   task automatic send(input logic [1:0] t, input logic [31:0] lo, input logic vc);
      logic [DATAW-1:0] d;
      bit acc;
      int tries;
      d = mk(t, lo);
      acc = 0;
      tries = 0;
      while (!acc && tries < 64) begin
         step(d, 1'b1, vc, acc);
         tries++;
      end
      chk("send_accepted", acc, 1'b1);
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++) step('0, 1'b0, 1'b0, acc);
   endtask

   // Asynchronous reset asserted between clock edges, checked before the next edge.
   task automatic reset_check();
      idata = '0; ivalid = 0; ivch = 0;
      #2 rst_ = 1'b0;
      #1;
      model_clear();
      chk("rst_ovalid_0", ovalid_0, 1'b0);
      chk("rst_ovalid_1", ovalid_1, 1'b0);
      chk("rst_odata_0", odata_0, '0);
      chk("rst_odata_1", odata_1, '0);
      chk("rst_ovch", {ovch_1, ovch_0}, '0);
      chk("rst_err_drop", err_drop, 1'b0);
      chk("rst_drop_cnt", drop_cnt, '0);
      chk("rst_iready", iready, 1'b1);
      @(negedge clk);
      rst_ = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit acc;
      int r;
      rst_ = 1'b1; idata = '0; ivalid = 0; ivch = 0; ordy_0 = 1; ordy_1 = 1;
      model_clear();
      @(posedge clk); #1;
      reset_check();

      // Packet to port 1 with consumer always ready.
      send(T_HEAD, 32'h09, 1'b0);
      for (int i = 0; i < 20; i++) send(T_DATA, $urandom, 1'b0);
      send(T_TAIL, $urandom, 1'b0);
      idle(2);

      // Packet to port 0 on vch 1.
      send(T_HEAD, 32'h04, 1'b1);
      for (int i = 0; i < 3; i++) send(T_DATA, $urandom, 1'b1);
      send(T_TAIL, $urandom, 1'b1);
      idle(2);

      // Backpressure: port 0 stalls, fills after 4 flits, then drains.
      ordy_0 = 0;
      send(T_HEAD, 32'h04, 1'b0);
      for (int i = 0; i < 3; i++) send(T_DATA, $urandom, 1'b0);
      step(mk(T_DATA, 32'h55), 1'b1, 1'b0, acc);
      chk("bp_blocked", acc, 1'b0);
      chk("bp_iready_low", iready, 1'b0);
      ordy_0 = 1;
      send(T_DATA, 32'h56, 1'b0);
      send(T_DATA, 32'h57, 1'b0);
      send(T_TAIL, 32'h58, 1'b0);
      idle(6);

      // Protocol errors.
      send(T_DATA, 32'h10, 1'b0);
      chk("drop1_cnt", drop_cnt, 8'd1);
      send(T_HEAD, 32'h04, 1'b0);
      send(T_HEAD, 32'h09, 1'b0);
      chk("drop2_cnt", drop_cnt, 8'd2);
      send(T_TAIL, 32'h11, 1'b0);
      idle(2);
      for (int i = 0; i < 300; i++) send(T_DATA, 32'h20, 1'b0);
      chk("drop_sat", drop_cnt, 8'd255);
      idle(1);

      // Back-to-back packets, no bubble between TAIL and next HEAD.
      send(T_HEAD, 32'h04, 1'b0);
      send(T_TAIL, 32'h30, 1'b0);
      send(T_HEAD, 32'h09, 1'b1);
      send(T_TAIL, 32'h31, 1'b1);
      idle(3);

      // Port 0 stalled and full; port 1 still flows.
      ordy_0 = 0;
      send(T_HEAD, 32'h04, 1'b0);
      send(T_DATA, 32'h40, 1'b0);
      send(T_DATA, 32'h41, 1'b0);
      send(T_TAIL, 32'h42, 1'b0);
      send(T_HEAD, 32'h09, 1'b0);
      send(T_DATA, 32'h43, 1'b0);
      send(T_TAIL, 32'h44, 1'b0);
      ordy_0 = 1;
      idle(6);

      // Reset mid-packet.
      ordy_0 = 0;
      send(T_HEAD, 32'h04, 1'b0);
      send(T_DATA, 32'h50, 1'b0);
      send(T_DATA, 32'h51, 1'b0);
      reset_check();
      ordy_0 = 1;
      send(T_DATA, 32'h52, 1'b0);
      chk("post_rst_drop", err_drop, 1'b1);
      send(T_HEAD, 32'h09, 1'b0);
      send(T_TAIL, 32'h53, 1'b0);
      idle(3);

      // Randomized traffic with random consumer stalls.
      for (int i = 0; i < 600; i++) begin
         ordy_0 = ($urandom_range(0, 3) != 0);
         ordy_1 = ($urandom_range(0, 3) != 0);
         r = $urandom_range(0, 9);
         step(mk((r == 0) ? T_NONE : (r == 1) ? T_HEAD : (r < 8) ? T_DATA : T_TAIL, $urandom),
              ($urandom_range(0, 4) != 0), 1'($urandom), acc);
      end
      ordy_0 = 1; ordy_1 = 1;
      idle(8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
